// File: rtl/fmac_pkg.sv
// Shared types, word geometry and FloPoCo field helpers for the dot-product sequencer.
package fmac_pkg;

  localparam int unsigned WE = 8;
  localparam int unsigned WF = 23;
  // 2 exception bits, sign, exponent, fraction
  localparam int unsigned W = WE + WF + 3;
  // All-zero word encodes FloPoCo +0 (exn = 2'b00).
  localparam logic [W-1:0] ZERO = '0;

  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

  function automatic logic [1:0] fp_exn(input logic [W-1:0] v);
    return v[W-1 -: 2];
  endfunction

  function automatic logic fp_sign(input logic [W-1:0] v);
    return v[WE+WF];
  endfunction

  function automatic logic [WE-1:0] fp_exp(input logic [W-1:0] v);
    return v[WF +: WE];
  endfunction

  function automatic logic [WF-1:0] fp_frac(input logic [W-1:0] v);
    return v[WF-1:0];
  endfunction

endpackage

// File: rtl/fmac_dot_sequencer_if.sv
// Operand stream, fmul/fadd core hookup and result handshake of the dot-product sequencer.
interface fmac_dot_sequencer_if #(
  parameter int unsigned W     = fmac_pkg::W,
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] n_elems;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_x;
  logic [W-1:0]     in_w;
  logic [W-1:0]     fmul_x;
  logic [W-1:0]     fmul_y;
  logic             fmul_ce;
  logic [W-1:0]     fmul_r;
  logic [W-1:0]     fadd_x;
  logic [W-1:0]     fadd_y;
  logic             fadd_ce;
  logic [W-1:0]     fadd_r;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic [W-1:0]     res;

  // Sequencer side
  modport slave (
    input  start, n_elems, in_valid, in_x, in_w, fmul_r, fadd_r, res_ready,
    output in_ready, fmul_x, fmul_y, fmul_ce, fadd_x, fadd_y, fadd_ce, busy, res_valid, res
  );

  // Streamer / core / consumer side
  modport master (
    output start, n_elems, in_valid, in_x, in_w, fmul_r, fadd_r, res_ready,
    input  in_ready, fmul_x, fmul_y, fmul_ce, fadd_x, fadd_y, fadd_ce, busy, res_valid, res
  );
endinterface

// File: rtl/fmac_prod_fifo.sv
// First-word-fall-through product FIFO between the fmul output and the serial fadd issue.
module fmac_prod_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 34
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [Width-1:0]             push_data,
  input  logic                         pop,
  output logic [Width-1:0]             head,
  output logic [$clog2(Depth+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);
  localparam int unsigned PW = $clog2(Depth);
  localparam int unsigned CW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  // Storage, pointers (wrap naturally, Depth is a power of two) and occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Status and head word.
  always_comb begin
    head  = mem_q[rd_ptr_q];
    count = count_q;
    empty = (count_q == '0);
    full  = (count_q == CW'(Depth));
  end
endmodule

// File: rtl/fmac_dot_sequencer.sv
// Drives one shared fmul/fadd pair to accumulate sum(x[i]*w[i]) with a serial accumulator.
module fmac_dot_sequencer
  import fmac_pkg::*;
#(
  parameter int unsigned WE         = 8,
  parameter int unsigned WF         = 23,
  parameter int unsigned MUL_LAT    = 2,
  parameter int unsigned ADD_LAT    = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input logic                clk,
  input logic                reset,
  fmac_dot_sequencer_if.slave bus
);
  localparam int unsigned WD  = WE + WF + 3;
  localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ACW = $clog2(ADD_LAT + 1);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] n_q, accepted_q;
  logic [MUL_LAT-1:0] mul_vld_q;
  logic [ACW-1:0]   add_cnt_q;
  logic [WD-1:0]    acc_q, res_q;

  logic [WD-1:0]    fifo_head;
  logic [FCW-1:0]   fifo_count;
  logic             fifo_empty, fifo_full;
  logic             start_ok, accept, push, issue, retire, in_ready;
  int unsigned      outstanding;

  fmac_prod_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (WD)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (bus.fmul_r),
    .pop       (issue),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Handshake decisions; the credit counts pairs in the fmul pipe so a push can never be refused.
  always_comb begin
    outstanding = 32'(fifo_count) + 32'($countones(mul_vld_q));
    start_ok    = (state_q == IDLE) && bus.start;
    in_ready    = (state_q == RUN) && (accepted_q < n_q) && (outstanding < FIFO_DEPTH);
    accept      = in_ready && bus.in_valid;
    push        = mul_vld_q[MUL_LAT-1];
    issue       = (state_q == RUN) && (add_cnt_q == '0) && !fifo_empty;
    retire      = (state_q == RUN) && (accepted_q == n_q) && (mul_vld_q == '0) && fifo_empty
                  && (add_cnt_q == '0);
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = (bus.n_elems != '0) ? RUN : DONE;
      RUN:     if (retire) state_d = DONE;
      DONE:    if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Job counters, fmul valid tags, fadd latency counter, accumulator and result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      n_q        <= '0;
      accepted_q <= '0;
      mul_vld_q  <= '0;
      add_cnt_q  <= '0;
      acc_q      <= '0;
      res_q      <= '0;
    end else begin
      if (start_ok) begin
        n_q        <= bus.n_elems;
        accepted_q <= '0;
        if (bus.n_elems == '0) res_q <= '0;
      end
      if (accept) accepted_q <= accepted_q + CNT_W'(1);
      mul_vld_q <= (mul_vld_q << 1) | MUL_LAT'(accept);
      if (issue)                 add_cnt_q <= ACW'(ADD_LAT);
      else if (add_cnt_q != '0)  add_cnt_q <= add_cnt_q - ACW'(1);
      // fadd_r is valid in the last counted cycle.
      if (add_cnt_q == ACW'(1)) acc_q <= bus.fadd_r;
      if (retire) res_q <= acc_q;
      if ((state_q == DONE) && bus.res_ready) acc_q <= '0;
    end
  end

  // Outputs; operand buses are zero unless a transfer is happening.
  always_comb begin
    bus.in_ready  = in_ready;
    bus.fmul_x    = accept ? bus.in_x : '0;
    bus.fmul_y    = accept ? bus.in_w : '0;
    bus.fmul_ce   = (state_q != IDLE);
    bus.fadd_x    = issue ? acc_q : '0;
    bus.fadd_y    = issue ? fifo_head : '0;
    bus.fadd_ce   = (state_q != IDLE);
    bus.busy      = (state_q != IDLE);
    bus.res_valid = (state_q == DONE);
    bus.res       = res_q;
  end

  // The credit rule must keep the product FIFO from overflowing.
  assert property (@(posedge clk) disable iff (!reset) !(push && fifo_full && !issue));
endmodule

// File: tb/tb_fmac_dot_sequencer.sv
// Directed bench for fmac_dot_sequencer with behavioural pipelined fmul/fadd cores.
module tb_fmac_dot_sequencer;
  import fmac_pkg::*;

  localparam int unsigned MUL_LAT    = 2;
  localparam int unsigned ADD_LAT    = 3;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CNT_W      = 16;

  localparam logic [W-1:0] ONE   = {2'b01, 1'b0, 8'h7F, 23'h0};
  localparam logic [W-1:0] TWO   = {2'b01, 1'b0, 8'h80, 23'h0};
  localparam logic [W-1:0] FOUR  = {2'b01, 1'b0, 8'h81, 23'h0};
  localparam logic [W-1:0] EIGHT = {2'b01, 1'b0, 8'h82, 23'h0};

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  fmac_dot_sequencer_if #(.W(W), .CNT_W(CNT_W)) bus ();

  fmac_dot_sequencer #(
    .WE         (WE),
    .WF         (WF),
    .MUL_LAT    (MUL_LAT),
    .ADD_LAT    (ADD_LAT),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real fp_to_real(input logic [W-1:0] v);
    real m;
    int  e;
    if (fp_exn(v) != 2'b01) return 0.0;
    m = 1.0 + real'(fp_frac(v)) / 8388608.0;
    e = int'(fp_exp(v)) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return fp_sign(v) ? -m : m;
  endfunction

  function automatic logic [W-1:0] real_to_fp(input real v);
    real  a;
    int   e;
    logic s;
    if (v == 0.0) return ZERO;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    return {2'b01, s, 8'(e), 23'($rtoi((a - 1.0) * 8388608.0))};
  endfunction

  // Free-running core models, not reset, so stale results survive a sequencer reset.
  logic [W-1:0] mul_pipe [MUL_LAT] = '{default: '0};
  logic [W-1:0] add_pipe [ADD_LAT] = '{default: '0};

  always @(posedge clk) begin
    if (bus.fmul_ce) begin
      mul_pipe[0] <= real_to_fp(fp_to_real(bus.fmul_x) * fp_to_real(bus.fmul_y));
      for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
    end
  end

  always @(posedge clk) begin
    if (bus.fadd_ce) begin
      add_pipe[0] <= real_to_fp(fp_to_real(bus.fadd_x) + fp_to_real(bus.fadd_y));
      for (int i = 1; i < ADD_LAT; i++) add_pipe[i] <= add_pipe[i-1];
    end
  end

  assign bus.fmul_r = mul_pipe[MUL_LAT-1];
  assign bus.fadd_r = add_pipe[ADD_LAT-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Run one job with continuous in_valid; optionally hold res_ready low and pulse start mid-run.
  task automatic run_job(input int n, input logic [W-1:0] x, input logic [W-1:0] w,
                         input int hold, input bit glitch, input logic [W-1:0] exp_res,
                         input string tag);
    int           acc_n, iss_n;
    bit           done, glitched, stable;
    logic [W-1:0] got_res;
    real          prod;
    prod     = fp_to_real(x) * fp_to_real(w);
    acc_n    = 0;
    iss_n    = 0;
    done     = 0;
    glitched = 0;
    got_res  = '0;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.n_elems   = CNT_W'(n);
    bus.res_ready = (hold == 0);
    @(negedge clk);
    bus.n_elems  = '0;
    bus.in_x     = x;
    bus.in_w     = w;
    bus.in_valid = 1'b1;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      bus.start = 1'b0;
      if (glitch && acc_n == 2 && !glitched) begin
        bus.start   = 1'b1;
        bus.n_elems = CNT_W'(7);
        glitched    = 1;
      end
      #1;
      if (bus.res_valid) begin
        done    = 1;
        got_res = bus.res;
      end else begin
        if (acc_n == n) check({tag, "_ready_drop"}, 64'(bus.in_ready), 64'(0));
        if (bus.in_ready) check({tag, "_credit"}, 64'(acc_n - iss_n < FIFO_DEPTH), 64'(1));
        if (bus.fadd_y != '0) begin
          check({tag, "_fadd_acc"}, 64'(bus.fadd_x), 64'(real_to_fp(prod * iss_n)));
          check({tag, "_fadd_prod"}, 64'(bus.fadd_y), 64'(real_to_fp(prod)));
          iss_n++;
        end
        if (bus.in_ready) acc_n++;
      end
      @(negedge clk);
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    if (!done) check({tag, "_timeout"}, 64'(0), 64'(1));
    check({tag, "_res"}, 64'(got_res), 64'(exp_res));
    check({tag, "_accepts"}, 64'(acc_n), 64'(n));
    check({tag, "_issues"}, 64'(iss_n), 64'(n));
    stable = 1;
    for (int i = 0; i < hold; i++) begin
      #1;
      if (!bus.res_valid || bus.res != exp_res) stable = 0;
      @(negedge clk);
    end
    if (hold != 0) check({tag, "_held"}, 64'(stable), 64'(1));
    bus.res_ready = 1'b1;
    @(negedge clk);
    #1;
    check({tag, "_valid_clr"}, 64'(bus.res_valid), 64'(0));
    check({tag, "_idle"}, 64'(bus.busy), 64'(0));
    repeat (3) @(negedge clk);
    #1;
    check({tag, "_once"}, 64'(bus.res_valid), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.n_elems   = '0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_w      = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_valid", 64'(bus.res_valid), 64'(0));
    check("rst_ready", 64'(bus.in_ready), 64'(0));
    check("rst_res", 64'(bus.res), 64'(0));
    check("rst_ce", 64'({bus.fmul_ce, bus.fadd_ce}), 64'(0));
    reset = 1'b1;

    // 1. four 1.0*1.0 pairs, consumer always ready
    run_job(4, ONE, ONE, 0, 0, FOUR, "t1");
    // 2. four 2.0*1.0 pairs, result held for 10 cycles
    run_job(4, TWO, ONE, 10, 0, EIGHT, "t2");
    // 3. eight pairs, credit-limited by the FIFO
    run_job(8, ONE, ONE, 0, 0, EIGHT, "t3");

    // 4. empty job goes straight to DONE with +0
    @(negedge clk);
    bus.start     = 1'b1;
    bus.n_elems   = '0;
    bus.res_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_x      = ONE;
    bus.in_w      = ONE;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check("t4_valid", 64'(bus.res_valid), 64'(1));
    check("t4_res", 64'(bus.res), 64'(0));
    check("t4_busy", 64'(bus.busy), 64'(1));
    check("t4_ready", 64'(bus.in_ready), 64'(0));
    check("t4_no_issue", 64'({bus.fmul_x, bus.fadd_y}), 64'(0));
    bus.res_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    #1;
    check("t4_idle", 64'(bus.busy), 64'(0));

    // 5. start pulse with n_elems=7 during RUN is ignored
    run_job(4, ONE, ONE, 0, 1, FOUR, "t5");

    // 6. reset pulse mid-RUN, then a fresh single-pair job
    @(negedge clk);
    bus.start   = 1'b1;
    bus.n_elems = CNT_W'(4);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_x     = TWO;
    bus.in_w     = TWO;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check("t6_busy", 64'(bus.busy), 64'(0));
    check("t6_valid", 64'(bus.res_valid), 64'(0));
    check("t6_res", 64'(bus.res), 64'(0));
    check("t6_ce", 64'({bus.fmul_ce, bus.fadd_ce}), 64'(0));
    check("t6_data", 64'({bus.fmul_x, bus.fadd_x} != '0), 64'(0));
    run_job(1, ONE, ONE, 0, 0, ONE, "t6");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
